i_main_memory: RTL
==================

// Module: i_main_memory
// PURPOSE
//  Instruction main memory that answers the I-cache refill interface (IREQ/IADDR in, 128-bit IDBUS out).
//  Sits on the memory side of the I-cache and returns one aligned 4-word line per request after a
//  programmable latency. A word-wide init port preloads the program image before or between fetches.
// PARAMETERS
//  MEM_AW   10  word-address width; storage depth is 2**MEM_AW 32-bit words
//  LATENCY  1   wait cycles between request capture and response (0 = respond on the next edge)
// PORTS
//  clk        in   1    system clock, all state updates on posedge
//  rst_n      in   1    asynchronous active-low reset
//  IREQ       in   1    refill request from the I-cache, level-sensitive
//  IADDR      in   32   byte address of the missing instruction
//  IDBUS      out  128  refill line; word k of the line is at [32k+31:32k]
//  IRDY       out  1    IDBUS holds the response line for the captured request (1-cycle pulse)
//  busy       out  1    request in progress (state != IDLE)
//  init_we    in   1    preload write strobe
//  init_addr  in   MEM_AW  preload word address
//  init_data  in   32   preload word
// BEHAVIOUR
//  Reset: state=IDLE, IDBUS=0, IRDY=0, busy=0, cnt=0. Storage array is not cleared.
//  Reset asserted mid-request aborts it at once; no IRDY follows.
//  Addressing: word index = IADDR[MEM_AW+1:2]. Line base = index with bits [1:0] cleared.
//  IADDR bits above MEM_AW+1 are ignored, so addresses wrap modulo the storage size. IADDR[1:0] are ignored.
//  FSM: IDLE -> WAIT -> RESP -> GAP -> IDLE
//   IDLE: if IREQ=1 and init_we=0, capture the line base and load cnt=LATENCY.
//         Go to RESP if LATENCY=0, otherwise go to WAIT.
//         If IREQ and init_we are both 1, the write wins and the request is re-sampled next cycle.
//   WAIT: cnt decrements each cycle. When cnt==1, read the 4 words into IDBUS and go to RESP.
//   RESP: IRDY=1 for exactly one cycle. Go to GAP unconditionally.
//   GAP:  one bubble cycle so a still-high IREQ is not re-captured before the cache refills. Go to IDLE.
//  IDBUS is registered. It is loaded on the edge entering RESP and holds its value until the next such edge.
//  The cache may therefore sample IDBUS in any cycle after IRDY.
//  Request-to-IRDY latency: LATENCY+1 cycles after the capture edge. Back-to-back request period: LATENCY+3.
//  IREQ dropping after capture does not cancel the request; the response still completes.
//  IADDR changing after capture is ignored.
//  init_we writes mem[init_addr]=init_data on posedge in any state.
//  A write on the same edge that loads IDBUS is not visible in that response (old data is returned).
//  A write on any earlier edge is visible.
//  busy=1 in WAIT, RESP and GAP.
// CONFIGURATION
//  IMEM_CRITICAL_WORD_FIRST_EN
//   Defined: IDBUS is rotated so the requested word (IADDR[3:2]) is at [31:0] and the following words
//   (wrapping within the line) are in ascending lanes. This suits a cache that only uses data_in[31:0].
//   Undefined: IDBUS is naturally aligned, with line word 0 at [31:0] and word 3 at [127:96].
// TESTING
//  T1 reset: assert rst_n=0 mid-WAIT -> IRDY=0, busy=0, IDBUS=0 immediately; no IRDY after release.
//  T2 preload mem[0..3]=A0,A1,A2,A3 and set LATENCY=1; IREQ=1, IADDR=0x0 ->
//     IRDY at capture+2 with IDBUS={A3,A2,A1,A0}; busy for 3 cycles.
//  T3 IMEM_CRITICAL_WORD_FIRST_EN defined, IADDR=0x8 -> IDBUS={A1,A0,A3,A2}.
//     Without the macro -> IDBUS={A3,A2,A1,A0}.
//  T4 IREQ held high continuously with LATENCY=2 -> IRDY pulses exactly every 5 cycles, one cycle wide.
//  T5 MEM_AW=10, IADDR=0x0000_1004 -> returns the line at word 0 (wrap).
//     A write of 0xDEAD to word 1 on the IDBUS-load edge -> old word returned; the next request returns 0xDEAD.
//  T6 IREQ and init_we high together in IDLE -> no capture that cycle; capture on the following cycle;
//     IREQ dropped in WAIT -> IRDY still issued.

Source files
------------

// File: rtl/i_main_memory.sv
// Instruction main memory serving I-cache line refills after a programmable latency.
// Define IMEM_CRITICAL_WORD_FIRST_EN to rotate the requested word into IDBUS[31:0].
module i_main_memory #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IREQ,
    input  logic [31:0]       IADDR,
    output logic [127:0]      IDBUS,
    output logic              IRDY,
    output logic              busy,
    input  logic              init_we,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [31:0]       init_data
);

    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [MEM_AW-3:0] base;
    logic [MEM_AW-3:0] line_sel;
    logic [31:0]       mem [2**MEM_AW];
    logic [31:0]       word [4];
    logic [127:0]      line;

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
    end

    // With zero latency the line is read straight from the live address.
    always_comb begin
        line_sel = base;
        if (state == IDLE) begin
            line_sel = IADDR[MEM_AW+1:4];
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_word
        assign word[k] = mem[{line_sel, 2'(k)}];
    end

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
    logic [1:0] crit;
    logic [1:0] crit_sel;
    logic       unused_addr;

    assign crit_sel = (state == IDLE) ? IADDR[3:2] : crit;
    assign unused_addr = ^{IADDR[31:MEM_AW+2], IADDR[1:0]};

    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign line[32*j +: 32] = word[crit_sel + 2'(j)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit <= '0;
        end else if (state == IDLE && IREQ && !init_we) begin
            crit <= IADDR[3:2];
        end
    end
`else
    logic unused_addr;

    assign unused_addr = ^{IADDR[31:MEM_AW+2], IADDR[3:0]};

    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign line[32*j +: 32] = word[j];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            IDBUS <= '0;
            IRDY  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            base  <= '0;
        end else begin
            IRDY <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A simultaneous preload wins; the request is re-sampled next cycle.
                    if (IREQ && !init_we) begin
                        base <= IADDR[MEM_AW+1:4];
                        cnt  <= CW'(LATENCY);
                        busy <= 1'b1;
                        if (LATENCY == 0) begin
                            IDBUS <= line;
                            IRDY  <= 1'b1;
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        IDBUS <= line;
                        IRDY  <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= GAP;
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
